// File: rtl/gen_case_ser_tx.sv
// Parallel-to-serial transmitter, one bit per clock; the frame format
// (bit order, start/stop bits) is selected at elaboration by MODE.
module gen_case_ser_tx #(
    parameter int W    = 8,
    parameter int MODE = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         in_ready,
    output logic         ser_out,
    output logic         ser_valid,
    output logic         busy
);

    localparam int CW = $clog2(W) + 1;
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t         state, state_next;
    logic [W-1:0]   shreg, shreg_next;
    logic [CW-1:0]  cnt, cnt_next;

    logic           has_start;
    logic           has_stop;
    logic [W-1:0]   shifted;
    logic           data_bit;
    logic           last_cycle;
    logic           accept;
    state_t         first_state;

    generate
        if (W < 2 || W > 32) begin : g_bad_w
            $error("gen_case_ser_tx: W must be in 2..32");
        end

        case (MODE)
            0: begin : g_msb
                assign has_start = 1'b0;
                assign has_stop  = 1'b0;
                assign data_bit  = shreg[W-1];
                assign shifted   = {shreg[W-2:0], 1'b0};
            end
            1: begin : g_lsb
                assign has_start = 1'b0;
                assign has_stop  = 1'b0;
                assign data_bit  = shreg[0];
                assign shifted   = {1'b0, shreg[W-1:1]};
            end
            2: begin : g_start_msb
                assign has_start = 1'b1;
                assign has_stop  = 1'b0;
                assign data_bit  = shreg[W-1];
                assign shifted   = {shreg[W-2:0], 1'b0};
            end
            3: begin : g_start_lsb_stop
                assign has_start = 1'b1;
                assign has_stop  = 1'b1;
                assign data_bit  = shreg[0];
                assign shifted   = {1'b0, shreg[W-1:1]};
            end
            default: begin : g_bad_mode
                $error("gen_case_ser_tx: MODE must be 0..3");
            end
        endcase
    endgenerate

    // The final bit of a frame is the stop bit when present, else the last data bit.
    assign last_cycle  = has_stop ? (state == STOP) : (state == DATA && cnt == LAST);
    assign in_ready    = (state == IDLE) || last_cycle;
    assign accept      = in_valid && in_ready;
    assign first_state = has_start ? START : DATA;
    assign ser_valid   = (state != IDLE);
    assign busy        = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            shreg <= '0;
            cnt   <= '0;
        end else begin
            state <= state_next;
            shreg <= shreg_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        shreg_next = shreg;
        cnt_next   = cnt;
        ser_out    = 1'b1;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = first_state;
                    shreg_next = in_data;
                end
            end
            START: begin
                ser_out    = 1'b0;
                state_next = DATA;
            end
            DATA: begin
                ser_out    = data_bit;
                shreg_next = shifted;
                if (cnt == LAST) begin
                    cnt_next = '0;
                    if (has_stop) begin
                        state_next = STOP;
                    end else if (accept) begin
                        state_next = first_state;
                        shreg_next = in_data;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            STOP: begin
                ser_out = 1'b1;
                if (accept) begin
                    state_next = first_state;
                    shreg_next = in_data;
                end else begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: doc/gen_case_ser_tx.md
Name: gen_case_ser_tx

Overview:
- Parallel-to-serial transmitter, one bit per clock.
- Counterpart to the team's generate-case capture/receive blocks: drives the serial stream those blocks sample.
- Frame format chosen at elaboration by a generate case on MODE. Sits between a valid/ready word source and a single-wire serial link.

Parameters:
- W, 8: data word width; legal range 2..32.
- MODE, 0: frame format. 0 = MSB first, no framing. 1 = LSB first, no framing. 2 = start bit, then MSB first. 3 = start bit, then LSB first, then stop bit.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  source has a word.
- in_data  input  W  word to transmit.
- in_ready  output  1  block accepts in_data this cycle.
- ser_out  output  1  serial bit.
- ser_valid  output  1  ser_out carries a frame bit this cycle.
- busy  output  1  frame in progress.

Behaviour:
- Clock and reset (already decided): one clock, clk; reset rst_n is asynchronous, active-low.
- Reset values: ser_out=1, ser_valid=0, busy=0, in_ready=1, FSM=IDLE, bit counter=0, shift register=0.
- Reset asserted mid-frame aborts the frame immediately. No partial bits follow deassertion.
- FSM states:
  - IDLE
  - START (MODE 2/3 only)
  - DATA
  - STOP (MODE 3 only)
- Generate case on MODE:
  - Instantiates only the states and shift direction needed.
  - Any other MODE value is an elaboration error via the generate default branch.
  - W outside 2..32 is also an elaboration error.
- Accept rule: a word is taken when in_valid && in_ready at a rising edge, and is latched into the shift register.
- in_ready = (state==IDLE) || (last cycle of current frame). It is combinational from registered state only, never from in_valid.
- Latency: the first frame bit appears on ser_out, with ser_valid=1, in the cycle after acceptance.
- Frame sequences (one bit per cycle):
  - MODE 0: bits W-1 down to 0.
  - MODE 1: bits 0 up to W-1.
  - MODE 2: a 0 start bit, then bits W-1 down to 0.
  - MODE 3: a 0 start bit, then bits 0 up to W-1, then a 1 stop bit.
- Frame lengths: W cycles for MODE 0/1, W+1 for MODE 2, W+2 for MODE 3.
- Bit counter: $clog2(W)+1 bits wide, counts data bits 0..W-1. Wrap to 0 on the last data bit.
- Back-to-back frames:
  - Acceptance in the last frame cycle starts the next frame on the following cycle, with zero idle gap.
  - ser_valid stays 1 continuously across the boundary.
  - Transitions: last data bit in MODE 0/1/2, or STOP in MODE 3, goes to START/DATA on acceptance, else to IDLE.
- Idle line: ser_out=1 and ser_valid=0 whenever no frame bit is driven.
- busy = (state!=IDLE). It is registered and aligned with ser_valid.
- in_data changes while busy are ignored; only the latched copy is shifted.
- in_valid deasserted in the last frame cycle: return to IDLE, ser_valid=0 on the next cycle.

Test Plan:
- Reset/idle (any MODE): rst_n=0 then release, in_valid=0 for 5 cycles -> ser_out=1, ser_valid=0, busy=0, in_ready=1 throughout.
- Bit order (MODE=0, W=8): accept 8'hA5 -> next 8 cycles ser_out = 1,0,1,0,0,1,0,1 with ser_valid=1. Then ser_valid=0, in_ready=1.
- Full framing (MODE=3, W=8): accept 8'h81 -> ser_out = 0 (start), 1,0,0,0,0,0,0,1 (LSB first), 1 (stop) over 10 cycles. in_ready=0 for the first 9 of those cycles, 1 in the stop cycle.
- Back-to-back (MODE=2, W=4): in_valid held high with 4'hC then 4'h3 -> ser_out = 0,1,1,0,0,0,0,0,1,1 over 10 contiguous cycles. ser_valid never drops; exactly 2 handshakes occur.
- Mid-frame reset (MODE=1, W=8): accept 8'hFF, assert rst_n after 3 bits -> outputs go to reset values in the same cycle, asynchronously. After release, no residual bits; the next accepted word 8'h01 transmits cleanly, LSB first.
- Ignored input (MODE=0, W=8): accept 8'h0F, then change in_data to 8'hF0 with in_valid=0 while busy -> stream is 0,0,0,0,1,1,1,1.
